// File: rtl/uart_cmd_rx_if.sv
// Byte-in / command-out handshake bundle between the UART receiver, the
// command-frame assembler and the host logic.
interface uart_cmd_rx_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic       clr_cmd_rdy;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic [15:0] data;
  logic       frame_err;
  logic       ovr;

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rx_rdy, cmd_rdy, cmd, data, frame_err, ovr
  );

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rx_rdy, cmd_rdy, cmd, data, frame_err, ovr
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// Assembles 3-byte UART frames (cmd, data hi, data lo) into a 24-bit command
// with a ready/clear handshake; partial frames are dropped after an idle timeout.
module uart_cmd_rx #(
  parameter int TIMEOUT = 100000,
  parameter int TMO_W   = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_cmd_rx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        cmd_sh_q, cmd_sh_d;
  logic [7:0]        hi_sh_q, hi_sh_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [15:0]       data_q, data_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              rx_rdy_q;
  logic              clr_rx_rdy_q;
  logic              frame_err_q, frame_err_d;
  logic              ovr_q, ovr_d;
  logic              acc_s;
  logic              tmo_s;
  logic              complete_s;

  // A held rx_rdy level counts as one byte: only its rising edge is accepted.
  assign acc_s = bus.rx_rdy & ~rx_rdy_q;
  assign tmo_s = (tmr_q == TMO_W'(TIMEOUT - 1));

  // Frame FSM, inter-byte timer and shadow capture; acc beats timeout.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    cmd_sh_d    = cmd_sh_q;
    hi_sh_d     = hi_sh_q;
    frame_err_d = 1'b0;
    complete_s  = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (acc_s) begin
          cmd_sh_d = bus.rx_data;
          state_d  = GET_HI;
        end else begin
          state_d = IDLE;
        end
      end
      GET_HI: begin
        if (acc_s) begin
          hi_sh_d = bus.rx_data;
          tmr_d   = '0;
          state_d = GET_LO;
        end else if (tmo_s) begin
          frame_err_d = 1'b1;
          tmr_d       = '0;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      GET_LO: begin
        if (acc_s) begin
          complete_s = 1'b1;
          tmr_d      = '0;
          state_d    = IDLE;
        end else if (tmo_s) begin
          frame_err_d = 1'b1;
          tmr_d       = '0;
          state_d     = IDLE;
        end else begin
          tmr_d = tmr_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output command registers; a completing frame wins over a host clear.
  always_comb begin
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q;
    ovr_d     = 1'b0;
    if (complete_s) begin
      cmd_d     = cmd_sh_q;
      data_d    = {hi_sh_q, bus.rx_data};
      cmd_rdy_d = 1'b1;
      ovr_d     = cmd_rdy_q & ~bus.clr_cmd_rdy;
    end else if (bus.clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      cmd_sh_q     <= 8'h00;
      hi_sh_q      <= 8'h00;
      cmd_q        <= 8'h00;
      data_q       <= 16'h0000;
      cmd_rdy_q    <= 1'b0;
      rx_rdy_q     <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cmd_sh_q     <= cmd_sh_d;
      hi_sh_q      <= hi_sh_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cmd_rdy_q    <= cmd_rdy_d;
      rx_rdy_q     <= bus.rx_rdy;
      clr_rx_rdy_q <= acc_s;
      frame_err_q  <= frame_err_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.clr_rx_rdy = clr_rx_rdy_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.cmd        = cmd_q;
  assign bus.data       = data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: framing, timeout, held level, overrun,
// set/clear collision and mid-frame reset, with hand-computed expectations.
module tb_uart_cmd_rx;
  localparam int TMO = 20;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   clr_cnt;
  int   ferr_cnt;
  int   ovr_cnt;

  uart_cmd_rx_if bus_if ();

  uart_cmd_rx #(.TIMEOUT(TMO), .TMO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_if.clr_rx_rdy) clr_cnt <= clr_cnt + 1;
    if (bus_if.frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (bus_if.ovr)        ovr_cnt <= ovr_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise rx_rdy, wait for the acknowledge (expected one cycle later), drop it.
  task automatic send_byte(input logic [7:0] b, input bit clr_with);
    int n;
    n = 0;
    bus_if.rx_data = b;
    bus_if.rx_rdy  = 1'b1;
    if (clr_with) bus_if.clr_cmd_rdy = 1'b1;
    do begin
      @(posedge clk);
      #1;
      bus_if.clr_cmd_rdy = 1'b0;
      n++;
    end while (!bus_if.clr_rx_rdy && n < 8);
    vectors++;
    if (!bus_if.clr_rx_rdy || n != 1) begin
      miscompares++;
      $display("FAIL ack_latency byte=%h: got %0d cycles (clr=%b), want 1", b, n, bus_if.clr_rx_rdy);
    end
    bus_if.rx_rdy = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] ec, input logic [15:0] ed);
    vectors++;
    if (bus_if.cmd_rdy !== 1'b1 || bus_if.cmd !== ec || bus_if.data !== ed) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b cmd=%h data=%h, want rdy=1 cmd=%h data=%h",
               nm, bus_if.cmd_rdy, bus_if.cmd, bus_if.data, ec, ed);
    end
  endtask

  task automatic clear_cmd();
    bus_if.clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus_if.clr_cmd_rdy = 1'b0;
    vectors++;
    if (bus_if.cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_cmd_rdy: got %b, want 0", bus_if.cmd_rdy);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({bus_if.clr_rx_rdy, bus_if.cmd_rdy, bus_if.cmd, bus_if.data, bus_if.frame_err, bus_if.ovr} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b cmd=%h data=%h", bus_if.cmd_rdy, bus_if.cmd, bus_if.data);
    end
    idle(3);
    rst_n = 1'b1;
    idle(2);
    vectors++;
    if (bus_if.cmd_rdy !== 1'b0 || clr_cnt !== 0 || ferr_cnt !== 0 || ovr_cnt !== 0) begin
      miscompares++;
      $display("FAIL post_reset: got rdy=%b clr=%0d ferr=%0d ovr=%0d, want all 0",
               bus_if.cmd_rdy, clr_cnt, ferr_cnt, ovr_cnt);
    end
  endtask

  task automatic test_normal();
    int c0;
    c0 = clr_cnt;
    send_byte(8'hA5, 1'b0); idle(10);
    send_byte(8'h12, 1'b0); idle(10);
    vectors++;
    if (bus_if.cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_no_rdy: got %b, want 0", bus_if.cmd_rdy);
    end
    send_byte(8'h34, 1'b0);
    check_frame("normal_frame", 8'hA5, 16'h1234);
    idle(2);
    vectors++;
    if (clr_cnt - c0 !== 3) begin
      miscompares++;
      $display("FAIL normal_clr_pulses: got %0d, want 3", clr_cnt - c0);
    end
    clear_cmd();
  endtask

  task automatic test_timeout();
    int t0, lat, f0;
    f0  = ferr_cnt;
    lat = -1;
    send_byte(8'h01, 1'b0); idle(5);
    send_byte(8'h02, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.frame_err && lat < 0) lat = cyc - t0;
    end
    vectors++;
    if (lat !== TMO) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d, want %0d", lat, TMO);
    end
    vectors++;
    if (ferr_cnt - f0 !== 1 || bus_if.cmd_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_effect: got ferr=%0d rdy=%b, want 1 and 0", ferr_cnt - f0, bus_if.cmd_rdy);
    end
    send_byte(8'h03, 1'b0); idle(5);
    send_byte(8'h00, 1'b0); idle(5);
    send_byte(8'h07, 1'b0);
    check_frame("after_timeout", 8'h03, 16'h0007);
    clear_cmd();
  endtask

  task automatic test_held_level();
    int c0;
    c0 = clr_cnt;
    bus_if.rx_data = 8'h55;
    bus_if.rx_rdy  = 1'b1;
    idle(10);
    bus_if.rx_rdy = 1'b0;
    idle(1);
    vectors++;
    if (clr_cnt - c0 !== 1) begin
      miscompares++;
      $display("FAIL held_clr_pulses: got %0d, want 1", clr_cnt - c0);
    end
    send_byte(8'h66, 1'b0); idle(2);
    send_byte(8'h77, 1'b0);
    check_frame("held_level", 8'h55, 16'h6677);
    clear_cmd();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    send_byte(8'h10, 1'b0); idle(3);
    send_byte(8'hAA, 1'b0); idle(3);
    send_byte(8'hBB, 1'b0);
    check_frame("ovr_first", 8'h10, 16'hAABB);
    idle(3);
    send_byte(8'h20, 1'b0); idle(3);
    send_byte(8'hCC, 1'b0); idle(3);
    send_byte(8'hDD, 1'b0);
    check_frame("ovr_second", 8'h20, 16'hCCDD);
    idle(2);
    vectors++;
    if (ovr_cnt - o0 !== 1) begin
      miscompares++;
      $display("FAIL ovr_pulses: got %0d, want 1", ovr_cnt - o0);
    end
  endtask

  task automatic test_back_to_back_collision();
    int o0;
    o0 = ovr_cnt;
    send_byte(8'h30, 1'b0); idle(2);
    send_byte(8'h31, 1'b0); idle(2);
    send_byte(8'h32, 1'b1);
    check_frame("set_clr_collision", 8'h30, 16'h3132);
    idle(2);
    vectors++;
    if (ovr_cnt !== o0 || bus_if.cmd_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_ovr: got ovr=%0d rdy=%b, want 0 and 1", ovr_cnt - o0, bus_if.cmd_rdy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    send_byte(8'h99, 1'b0);
    idle(1);
    #3 rst_n = 1'b0;
    #2;
    vectors++;
    if ({bus_if.clr_rx_rdy, bus_if.cmd_rdy, bus_if.cmd, bus_if.data, bus_if.frame_err, bus_if.ovr} !== 28'h0) begin
      miscompares++;
      $display("FAIL midframe_reset_outputs: got rdy=%b cmd=%h data=%h", bus_if.cmd_rdy, bus_if.cmd, bus_if.data);
    end
    idle(3);
    rst_n = 1'b1;
    f0 = ferr_cnt;
    idle(2);
    send_byte(8'h44, 1'b0); idle(3);
    send_byte(8'h55, 1'b0); idle(3);
    send_byte(8'h66, 1'b0);
    check_frame("after_reset", 8'h44, 16'h5566);
    idle(25);
    vectors++;
    if (ferr_cnt !== f0) begin
      miscompares++;
      $display("FAIL reset_ferr: got %0d pulses, want 0", ferr_cnt - f0);
    end
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    cyc                = 0;
    clr_cnt            = 0;
    ferr_cnt           = 0;
    ovr_cnt            = 0;
    rst_n              = 1'b0;
    bus_if.rx_rdy      = 1'b0;
    bus_if.rx_data     = 8'h00;
    bus_if.clr_cmd_rdy = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_held_level();
    test_overrun();
    test_back_to_back_collision();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
